// File: rtl/signal_conditioner.sv
// Three-channel synchroniser and debouncer feeding the first-signal detector.
// Each channel produces a clean level and a one-cycle rise pulse.
module signal_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  input  logic c_raw,
  output logic a,
  output logic b,
  output logic c,
  output logic a_rise,
  output logic b_rise,
  output logic c_rise,
  output logic any_active
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);

  logic [2:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [CW-1:0]          cnt_q  [3];
  logic [CW-1:0]          cnt_d  [3];
  logic [2:0]             s;
  logic [2:0]             lvl_q, lvl_d;
  logic [2:0]             rise_q, rise_d;
  logic                   any_q;

  assign raw = {c_raw, b_raw, a_raw};

  // Next level is computed combinationally so any_active registers on the same edge.
  always_comb begin
    s      = '0;
    lvl_d  = lvl_q;
    rise_d = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      s[i]     = sync_q[i][SYNC_STAGES-1];
      if (s[i] != lvl_q[i]) begin
        if (cnt_q[i] == TC) begin
          lvl_d[i]  = s[i];
          rise_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      lvl_q  <= '0;
      rise_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      any_q  <= |lvl_d;
    end
  end

  assign a          = lvl_q[0];
  assign b          = lvl_q[1];
  assign c          = lvl_q[2];
  assign a_rise     = rise_q[0];
  assign b_rise     = rise_q[1];
  assign c_rise     = rise_q[2];
  assign any_active = any_q;

endmodule

// File: tb/tb_signal_conditioner.sv
// Directed bench for signal_conditioner at default parameters and with DB_CYCLES=1.
module tb_signal_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_raw = 1'b0, b_raw = 1'b0, c_raw = 1'b0;
  logic a, b, c, a_rise, b_rise, c_rise, any_active;
  logic a1, b1, c1, a_rise1, b_rise1, c_rise1, any_active1;

  int errors = 0;
  int checks = 0;
  int rises;

  always #5 clk = ~clk;

  signal_conditioner dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
    .a(a), .b(b), .c(c), .a_rise(a_rise), .b_rise(b_rise), .c_rise(c_rise),
    .any_active(any_active)
  );

  signal_conditioner #(.SYNC_STAGES(2), .DB_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
    .a(a1), .b(b1), .c(c1), .a_rise(a_rise1), .b_rise(b_rise1), .c_rise(c_rise1),
    .any_active(any_active1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_abc", {29'd0, c, b, a}, 32'd0);
    chk("rst_rise", {29'd0, c_rise, b_rise, a_rise}, 32'd0);
    chk("rst_any", {31'd0, any_active}, 32'd0);
    chk("rst_cnt_a", 32'(dut.cnt_q[0]), 32'd0);

    // a_raw held high from before edge 0
    rst = 1'b0;
    a_raw = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick(1);
      if (e == 1) chk("db1_a_e1", {31'd0, a1}, 32'd0);
      if (e == 2) begin
        chk("db1_a_e2", {31'd0, a1}, 32'd1);
        chk("db1_rise_e2", {31'd0, a_rise1}, 32'd1);
      end
      if (e == 4) begin
        chk("lat_a_e4", {31'd0, a}, 32'd0);
        chk("lat_any_e4", {31'd0, any_active}, 32'd0);
      end
      if (e == 5) begin
        chk("lat_a_e5", {31'd0, a}, 32'd1);
        chk("lat_rise_e5", {31'd0, a_rise}, 32'd1);
        chk("lat_any_e5", {31'd0, any_active}, 32'd1);
      end
      if (e == 6) begin
        chk("lat_rise_e6", {31'd0, a_rise}, 32'd0);
        chk("lat_any_e6", {31'd0, any_active}, 32'd1);
      end
    end

    // b glitch: three synchronised high samples
    b_raw = 1'b1;
    tick(3);
    b_raw = 1'b0;
    for (int j = 3; j <= 8; j++) begin
      tick(1);
      chk("glitch_b", {31'd0, b}, 32'd0);
      chk("glitch_b_rise", {31'd0, b_rise}, 32'd0);
      if (j == 4) chk("glitch_cnt_peak", 32'(dut.cnt_q[1]), 32'd3);
      if (j == 5) chk("glitch_cnt_clr", 32'(dut.cnt_q[1]), 32'd0);
    end
    chk("glitch_a_hold", {31'd0, a}, 32'd1);

    // a and c rise together
    rst = 1'b1;
    a_raw = 1'b0;
    tick(1);
    chk("rst2_a", {31'd0, a}, 32'd0);
    rst = 1'b0;
    tick(1);
    a_raw = 1'b1;
    c_raw = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick(1);
      if (e == 4) chk("pair_e4", {29'd0, c, b, a}, 32'd0);
      if (e == 5) begin
        chk("pair_e5_abc", {29'd0, c, b, a}, 32'b101);
        chk("pair_e5_rise", {29'd0, c_rise, b_rise, a_rise}, 32'b101);
      end
    end

    // c falls: no rise pulse
    c_raw = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick(1);
      chk("fall_c_rise", {31'd0, c_rise}, 32'd0);
      if (e == 4) chk("fall_c_e4", {31'd0, c}, 32'd1);
      if (e == 5) chk("fall_c_e5", {31'd0, c}, 32'd0);
    end
    chk("fall_any", {31'd0, any_active}, 32'd1);

    // reset mid-count discards the partial count
    rst = 1'b1;
    a_raw = 1'b0;
    tick(1);
    rst = 1'b0;
    a_raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("abort_a", {31'd0, a}, 32'd0);
    chk("abort_rise", {31'd0, a_rise}, 32'd0);
    chk("abort_cnt", 32'(dut.cnt_q[0]), 32'd0);
    rst = 1'b0;
    rises = 0;
    for (int n = 0; n <= 7; n++) begin
      tick(1);
      rises += int'(a_rise);
      if (n < 5) chk("abort_a_low", {31'd0, a}, 32'd0);
      if (n == 5) begin
        chk("abort_a_e5", {31'd0, a}, 32'd1);
        chk("abort_rise_e5", {31'd0, a_rise}, 32'd1);
      end
    end
    chk("abort_rise_count", 32'(rises), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
